// File: rtl/b06_trace_capture.sv
// b06_trace_capture: cycle-stamped trace buffer for the b06 observable outputs.
// Samples {cc_mux, uscite, enable_count, ackout} into a first-word fall-through
// FIFO while a capture window is open, tagging each entry with a wrapping stamp.
// Optional build macro: TRACE_CHG_ONLY_EN -- push only on the first cycle of a
// window or when the observed value differs from the last pushed value.
module b06_trace_capture #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned STAMP_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cap_en,
   input  logic [1:0]               cc_mux,
   input  logic [1:0]               uscite,
   input  logic                     enable_count,
   input  logic                     ackout,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [STAMP_W+5:0]       rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     capturing
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = STAMP_W + 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [DW-1:0]        mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [STAMP_W-1:0]   stamp;
   logic [STAMP_W-1:0]   stamp_use_c;
   logic [5:0]           obs_c;
   logic                 restart_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 full_c;
   logic                 push_ok_c;
   logic [CW-1:0]        count_next_c;
`ifdef TRACE_CHG_ONLY_EN
   logic [5:0]           last_obs;
`endif

   assign obs_c       = {cc_mux, uscite, enable_count, ackout};
   assign full_c      = (count == CW'(DEPTH));
   assign pop_c       = rd_valid && rd_ready;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign push_ok_c   = push_c && (!full_c || pop_c);
   // A fresh window from IDLE restarts the stamp at zero for its first sample.
   assign stamp_use_c = restart_c ? '0 : stamp;
   // Head entry is shown only while valid, so reset leaves rd_data at zero.
   assign rd_data     = rd_valid ? mem[rd_ptr] : '0;

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode and push decision for the current edge.
   always_comb begin
      state_next = state;
      restart_c  = 1'b0;
      push_c     = 1'b0;
      case (state)
         IDLE: begin
            if (cap_en) begin
               state_next = CAPTURE;
               restart_c  = 1'b1;
            end
         end
         CAPTURE: begin
            if (!cap_en) state_next = DRAIN;
         end
         DRAIN: begin
            if (cap_en)             state_next = CAPTURE;
            else if (count == '0)   state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
`ifdef TRACE_CHG_ONLY_EN
      push_c = cap_en && ((state != CAPTURE) || (obs_c != last_obs));
`else
      push_c = cap_en;
`endif
   end

   // Occupancy after this edge's push/pop.
   always_comb begin
      count_next_c = count;
      if (push_ok_c && !pop_c)      count_next_c = count + CW'(1);
      else if (!push_ok_c && pop_c) count_next_c = count - CW'(1);
   end

   // Storage array; contents beyond the valid window are never observed.
   always_ff @(posedge clock) begin
      if (!reset && push_ok_c) mem[wr_ptr] <= {stamp_use_c, obs_c};
   end

   // Pointers, occupancy, stamp and status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stamp     <= '0;
         overflow  <= 1'b0;
         capturing <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
         count     <= count_next_c;
         rd_valid  <= (count_next_c != '0);
         capturing <= (state_next == CAPTURE);
         if (cap_en) stamp <= stamp_use_c + STAMP_W'(1);
         if (push_c && full_c && !pop_c) overflow <= 1'b1;
         else if (restart_c)             overflow <= 1'b0;
      end
   end

`ifdef TRACE_CHG_ONLY_EN
   // Last sample offered to the buffer, for change detection.
   always_ff @(posedge clock) begin
      if (reset)       last_obs <= '0;
      else if (push_c) last_obs <= obs_c;
   end
`endif

endmodule

// File: doc/b06_trace_capture.md
B06_TRACE_CAPTURE -- requirements
Module: b06_trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, buffer entries (power of two, 4..64).
REQ-002 Parameter STAMP_W, default 16, cycle-stamp width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cap_en  input  1  capture window request; high = capture, low = stop.
REQ-006 cc_mux  input  2  b06 output under observation.
REQ-007 uscite  input  2  b06 output under observation.
REQ-008 enable_count  input  1  b06 output under observation.
REQ-009 ackout  input  1  b06 output under observation.
REQ-010 rd_ready  input  1  consumer accepts head entry this cycle.
REQ-011 rd_valid  output  1  head entry available.
REQ-012 rd_data  output  STAMP_W+6  {stamp, cc_mux, uscite, enable_count, ackout} of head entry.
REQ-013 count  output  log2(DEPTH)+1  entries held.
REQ-014 overflow  output  1  sticky: a sample was dropped because the buffer was full.
REQ-015 capturing  output  1  high while FSM is in CAPTURE.

Function
REQ-016 obs = {cc_mux, uscite, enable_count, ackout}, 6 bits, sampled on every rising edge.
REQ-017 FSM states IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE when cap_en=1.
- CAPTURE -> DRAIN when cap_en=0.
- DRAIN -> IDLE when count=0 and no push is pending.
- DRAIN -> CAPTURE when cap_en=1; buffer contents are retained.
REQ-018 IDLE -> CAPTURE entry clears stamp to 0 and clears overflow; buffer contents are retained.
REQ-019 In CAPTURE, each cycle pushes {stamp, obs}; stamp then increments by 1 and wraps from 2^STAMP_W-1 to 0.
REQ-020 Latency: a sample taken at edge N is visible on rd_data/rd_valid after edge N (earliest read at cycle N+1) when the buffer was empty.
REQ-021 FIFO order, first-word fall-through; rd_valid = (count != 0); rd_data is the head entry whenever rd_valid=1.
REQ-022 Pop occurs when rd_valid and rd_ready are both 1; rd_data is don't-care when rd_valid=0.
REQ-023 Reads are allowed in every state, including CAPTURE.
REQ-024 Full buffer (count=DEPTH) with no pop: push is dropped, overflow is set, stamp still increments.
REQ-025 Full buffer with a simultaneous pop: push is accepted and count is unchanged.
REQ-026 Empty buffer: a pop request is ignored and count stays 0.
REQ-027 Simultaneous push and pop at any fill level: count is unchanged.
REQ-028 Pointers wrap modulo DEPTH.

Reset
REQ-029 When reset=1 at an edge, all other inputs are ignored and the following values apply after that edge:
- FSM = IDLE; pointers, count and stamp = 0; overflow = 0; capturing = 0; rd_valid = 0; rd_data = 0.
REQ-030 Reset mid-capture or mid-drain discards all buffered entries; no partial entry survives.

Configuration
REQ-031 Macro TRACE_CHG_ONLY_EN selects the push rule.
REQ-032 With TRACE_CHG_ONLY_EN defined, a CAPTURE push occurs only on the first cycle of a capture window, or when obs differs from the last pushed obs.
REQ-033 With TRACE_CHG_ONLY_EN defined, stamp increments every CAPTURE cycle regardless of whether a push occurs, so skipped cycles are recoverable.
REQ-034 Without TRACE_CHG_ONLY_EN, every CAPTURE cycle pushes, per REQ-019.

Verification
REQ-035 Reset, then cap_en=1 for 3 cycles with obs=6'h00,6'h15,6'h2A and rd_ready=0, then cap_en=0 -> count=3; entries {0,00},{1,15},{2,2A}; overflow=0; DRAIN held until read out.
REQ-036 DEPTH=16, cap_en=1 for 20 cycles, rd_ready=0 -> count=16, overflow=1, last stored stamp=15; then cap_en=0 with rd_ready=1 -> 16 pops, then IDLE.
REQ-037 Buffer full with rd_ready=1 during CAPTURE -> one pop and one push per cycle; count stays 16; overflow stays 0.
REQ-038 STAMP_W=4 with 18 capture cycles drained continuously -> stamps 0..15,0,1.
REQ-039 Reset asserted with count=5 in DRAIN -> next cycle count=0, rd_valid=0, FSM=IDLE, overflow=0.
REQ-040 TRACE_CHG_ONLY_EN defined, obs held at 6'h07 for 5 cycles, then 6'h08 -> 2 entries, stamps 0 and 5.
